// File: rtl/scratchmem_burst.sv
// rtl/scratchmem_burst.sv - burst-capable scratchpad RAM slave with fixed-latency in-order responses
module scratchmem_burst #(
    parameter int          DATA_WID   = 128,
    parameter int          DEPTH_LOG2 = 14,
    parameter int          RD_LAT     = 2,
    parameter logic [31:0] BASE_ADDR  = 32'hFFFC0000,
    parameter logic [31:0] ADDR_MASK  = 32'hFFFC0000,
    parameter              INIT_FILE  = "rom.mem"
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cs_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [2:0]            cti_i,
    input  logic [5:0]            blen_i,
    input  logic [7:0]            tid_i,
    input  logic [3:0]            cid_i,
    input  logic [DATA_WID/8-1:0] sel_i,
    input  logic [31:0]           adr_i,
    input  logic [DATA_WID-1:0]   dat_i,
    output logic                  next_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic [7:0]            tid_o,
    output logic [3:0]            cid_o,
    output logic [31:0]           adr_o,
    output logic [DATA_WID-1:0]   dat_o
);
    localparam int NB    = DATA_WID / 8;
    localparam int LB    = $clog2(NB);
    localparam int IW    = DEPTH_LOG2;
    localparam int DEPTH = 1 << IW;
    localparam int L     = RD_LAT - 1;

    typedef enum logic [1:0] {IDLE, RBURST, ERR} state_t;

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_q;
    logic       rst_n;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) rst_q <= 2'b00;
        else        rst_q <= {rst_q[0], 1'b1};
    end
    assign rst_n = rst_q[1];

    state_t          state, state_nx;
    logic [IW-1:0]   start_q, mask_q;
    logic [5:0]      k_q, cnt_q;
    logic [31:IW+LB] hi_q;
    logic [7:0]      tid_q;
    logic [3:0]      cid_q;

    logic          hit, accept, in_burst, is_burst, pow2;
    logic          issue_vld, issue_err, issue_rd, wr_en;
    logic [5:0]    blen_p1;
    logic [IW-1:0] req_idx, burst_idx, issue_idx;
    logic [31:0]   issue_adr;
    logic [7:0]    issue_tid;
    logic [3:0]    issue_cid;

    assign hit       = (adr_i & ADDR_MASK) == (BASE_ADDR & ADDR_MASK);
    assign accept    = cs_i & cyc_i & stb_i & (state == IDLE) & rst_n;
    assign next_o    = accept;
    assign in_burst  = (state == RBURST);
    assign is_burst  = (cti_i == 3'b010) || (cti_i == 3'b011);
    assign blen_p1   = blen_i + 6'd1;
    assign pow2      = (blen_i & blen_p1) == 6'd0;
    assign req_idx   = adr_i[IW+LB-1:LB];
    // mask_q is all ones for incrementing bursts, so one formula covers both kinds.
    assign burst_idx = (start_q & ~mask_q) | ((start_q + IW'(k_q)) & mask_q);
    assign issue_vld = accept | in_burst;
    assign issue_err = accept & ~hit;
    assign issue_rd  = in_burst | (accept & hit & ~we_i);
    assign wr_en     = accept & hit & we_i;
    assign issue_idx = in_burst ? burst_idx : req_idx;
    assign issue_tid = in_burst ? tid_q : tid_i;
    assign issue_cid = in_burst ? cid_q : cid_i;
    assign issue_adr = issue_err ? adr_i
                     : {(in_burst ? hi_q : adr_i[31:IW+LB]), issue_idx, {LB{1'b0}}};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) begin
                if (!hit)                                  state_nx = ERR;
                else if (!we_i && is_burst && blen_i != 0) state_nx = RBURST;
            end
            RBURST:  if (cnt_q == 6'd0) state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            start_q <= '0;
            mask_q  <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            tid_q   <= '0;
            cid_q   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                start_q <= req_idx;
                hi_q    <= adr_i[31:IW+LB];
                tid_q   <= tid_i;
                cid_q   <= cid_i;
                k_q     <= 6'd1;
                cnt_q   <= blen_i - 6'd1;
                mask_q  <= (cti_i == 3'b011 && pow2) ? IW'(blen_i) : '1;
            end else if (in_burst) begin
                k_q   <= k_q + 6'd1;
                cnt_q <= cnt_q - 6'd1;
            end
        end
    end

    logic [DATA_WID-1:0] mem [DEPTH];
    logic [DATA_WID-1:0] rd_data [RD_LAT];

    // Storage has no reset so contents survive a bus reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (sel_i[b]) mem[req_idx][b*8 +: 8] <= dat_i[b*8 +: 8];
            end
        end
        if (issue_rd) rd_data[0] <= mem[issue_idx];
        for (int s = 1; s < RD_LAT; s++) rd_data[s] <= rd_data[s-1];
    end

    logic [RD_LAT-1:0] vld_p, err_p, rd_p;
    logic [7:0]        tid_p [RD_LAT];
    logic [3:0]        cid_p [RD_LAT];
    logic [31:0]       adr_p [RD_LAT];

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            err_p <= '0;
            rd_p  <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                tid_p[s] <= '0;
                cid_p[s] <= '0;
                adr_p[s] <= '0;
            end
        end else begin
            vld_p[0] <= issue_vld;
            err_p[0] <= issue_err;
            rd_p[0]  <= issue_rd;
            tid_p[0] <= issue_tid;
            cid_p[0] <= issue_cid;
            adr_p[0] <= issue_adr;
            for (int s = 1; s < RD_LAT; s++) begin
                vld_p[s] <= vld_p[s-1];
                err_p[s] <= err_p[s-1];
                rd_p[s]  <= rd_p[s-1];
                tid_p[s] <= tid_p[s-1];
                cid_p[s] <= cid_p[s-1];
                adr_p[s] <= adr_p[s-1];
            end
        end
    end

    // Idle outputs are forced to zero so several slaves can be OR-combined.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            tid_o <= '0;
            cid_o <= '0;
            adr_o <= '0;
            dat_o <= '0;
        end else begin
            ack_o <= vld_p[L] & ~err_p[L];
            err_o <= vld_p[L] & err_p[L];
            tid_o <= vld_p[L] ? tid_p[L] : '0;
            cid_o <= vld_p[L] ? cid_p[L] : '0;
            adr_o <= vld_p[L] ? adr_p[L] : '0;
            dat_o <= (vld_p[L] & rd_p[L]) ? rd_data[L] : '0;
        end
    end

endmodule

// File: tb/tb_scratchmem_burst.sv
// tb/tb_scratchmem_burst.sv - randomized bench for scratchmem_burst against a queue-based reference model
module tb_scratchmem_burst;
    localparam int          DW   = 128;
    localparam int          IW   = 6;
    localparam int          NW   = 64;
    localparam logic [31:0] BASE = 32'hFFFC0000;
    localparam logic [31:0] MASK = 32'hFFFC0000;

    logic          clk_i = 1'b0;
    logic          rst_i, cs_i, cyc_i, stb_i, we_i;
    logic [2:0]    cti_i;
    logic [5:0]    blen_i;
    logic [7:0]    tid_i;
    logic [3:0]    cid_i;
    logic [15:0]   sel_i;
    logic [31:0]   adr_i;
    logic [DW-1:0] dat_i;
    logic          next_o, ack_o, err_o;
    logic [7:0]    tid_o;
    logic [3:0]    cid_o;
    logic [31:0]   adr_o;
    logic [DW-1:0] dat_o;

    scratchmem_burst #(
        .DATA_WID(DW), .DEPTH_LOG2(IW), .RD_LAT(2),
        .BASE_ADDR(BASE), .ADDR_MASK(MASK), .INIT_FILE("")
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cs_i(cs_i), .cyc_i(cyc_i), .stb_i(stb_i),
        .we_i(we_i), .cti_i(cti_i), .blen_i(blen_i), .tid_i(tid_i), .cid_i(cid_i),
        .sel_i(sel_i), .adr_i(adr_i), .dat_i(dat_i), .next_o(next_o), .ack_o(ack_o),
        .err_o(err_o), .tid_o(tid_o), .cid_o(cid_o), .adr_o(adr_o), .dat_o(dat_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc_cnt = 0;
    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int            due;
        bit            err;
        logic [7:0]    tid;
        logic [3:0]    cid;
        logic [31:0]   adr;
        logic [DW-1:0] dat;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] ref_mem [NW];
    int            busy_until = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_cnt);
        end
    endtask

    always @(negedge clk_i) begin : mon
        beat_t e;
        if (ack_o || err_o) begin
            if (exp_q.size() == 0) begin
                check("spurious_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("beat_time", cyc_cnt, e.due);
                check("beat_kind", {ack_o, err_o}, e.err ? 2'b01 : 2'b10);
                check("beat_tid", tid_o, e.tid);
                check("beat_cid", cid_o, e.cid);
                check("beat_adr", adr_o, e.adr);
                check("beat_dat", dat_o, e.dat);
            end
        end else begin
            check("idle_zero", (|dat_o) | (|tid_o) | (|cid_o) | (|adr_o), 0);
            if (exp_q.size() > 0 && exp_q[0].due <= cyc_cnt) begin
                check("beat_missing", 0, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic push_beat(input int due, input bit err, input logic [7:0] tid, input logic [3:0] cid,
                             input logic [31:0] adr, input logic [DW-1:0] dat);
        beat_t e;
        e.due = due; e.err = err; e.tid = tid; e.cid = cid; e.adr = adr; e.dat = dat;
        exp_q.push_back(e);
    endtask

    // Expected behaviour: responses 3 cycles after issue, burst word k from plain modular arithmetic.
    task automatic model(input int a, input bit we, input logic [2:0] cti, input logic [5:0] blen,
                         input logic [7:0] tid, input logic [3:0] cid, input logic [15:0] sel,
                         input logic [31:0] adr, input logic [DW-1:0] dat);
        int  w0, w, n, nw;
        bit  wrap;
        w0 = (adr >> 4) % NW;
        if ((adr & MASK) != (BASE & MASK)) begin
            push_beat(a + 3, 1'b1, tid, cid, adr, '0);
            busy_until = a + 2;
        end else if (we) begin
            for (int b = 0; b < 16; b++) if (sel[b]) ref_mem[w0][b*8 +: 8] = dat[b*8 +: 8];
            push_beat(a + 3, 1'b0, tid, cid, (adr & ~32'h3FF) | (w0 << 4), '0);
            busy_until = a + 1;
        end else begin
            nw   = int'(blen) + 1;
            n    = (cti == 3'b010 || cti == 3'b011) ? nw : 1;
            wrap = (cti == 3'b011) && ((nw & (nw - 1)) == 0);
            for (int k = 0; k < n; k++) begin
                w = wrap ? (w0 / nw) * nw + (w0 + k) % nw : (w0 + k) % NW;
                push_beat(a + 3 + k, 1'b0, tid, cid, (adr & ~32'h3FF) | (w << 4), ref_mem[w]);
            end
            busy_until = a + n;
        end
    endtask

    task automatic req(input bit we, input logic [2:0] cti, input logic [5:0] blen, input logic [7:0] tid,
                       input logic [3:0] cid, input logic [15:0] sel, input logic [31:0] adr,
                       input logic [DW-1:0] dat);
        int start, waited;
        cs_i = 1; cyc_i = 1; stb_i = 1; we_i = we; cti_i = cti; blen_i = blen;
        tid_i = tid; cid_i = cid; sel_i = sel; adr_i = adr; dat_i = dat;
        start  = cyc_cnt;
        waited = 0;
        @(negedge clk_i);
        while (!next_o && waited < 200) begin
            waited++;
            @(negedge clk_i);
        end
        if (!next_o) begin
            check("accept_timeout", 0, 1);
        end else begin
            check("accept_cycle", cyc_cnt, (start > busy_until) ? start : busy_until);
            model(cyc_cnt, we, cti, blen, tid, cid, sel, adr, dat);
        end
        @(posedge clk_i);
        #1;
        cs_i = 0; cyc_i = 0; stb_i = 0;
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [31:0] word_adr(input int w);
        return BASE + 32'(w * 16);
    endfunction

    logic [DW-1:0] d;
    logic [31:0]   a_r;
    logic [2:0]    cti_tab [8] = '{3'b000, 3'b010, 3'b011, 3'b011, 3'b010, 3'b001, 3'b111, 3'b000};

    initial begin
        rst_i = 1; cs_i = 0; cyc_i = 0; stb_i = 0; we_i = 0; cti_i = 0; blen_i = 0;
        tid_i = 0; cid_i = 0; sel_i = 0; adr_i = 0; dat_i = 0;
        #2 rst_i = 0;
        @(posedge clk_i); #1;
        check("rst_ack", ack_o, 0);
        check("rst_err", err_o, 0);
        check("rst_dat", dat_o, 0);
        check("rst_adr", adr_o, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1;
        repeat (4) @(posedge clk_i);
        #1;

        for (int w = 0; w < NW; w++) begin
            d = (w == 16) ? 128'h0123456789ABCDEF0123456789ABCDEF : rnd128();
            req(1, 3'b000, 6'd0, 8'(w), 4'(w), 16'hFFFF, word_adr(w), d);
        end

        req(0, 3'b000, 6'd0, 8'h5A, 4'h3, 16'h0000, BASE + 32'h100, '0);
        req(1, 3'b000, 6'd0, 8'h11, 4'h1, 16'h0003, word_adr(5), 128'hAAAA);
        req(0, 3'b000, 6'd0, 8'h12, 4'h2, 16'h0000, word_adr(5), '0);
        req(0, 3'b010, 6'd3, 8'h21, 4'h4, 16'h0000, word_adr(7), '0);
        req(0, 3'b011, 6'd3, 8'h22, 4'h5, 16'h0000, word_adr(6), '0);
        req(0, 3'b010, 6'd7, 8'h31, 4'h6, 16'h0000, 32'h0000_1000, '0);
        req(1, 3'b010, 6'd7, 8'h32, 4'h7, 16'hFFFF, 32'h1234_5670, rnd128());
        req(0, 3'b010, 6'd3, 8'h41, 4'h8, 16'h0000, word_adr(62), '0);
        req(0, 3'b011, 6'd7, 8'h42, 4'h9, 16'h0000, word_adr(13), '0);
        req(0, 3'b011, 6'd4, 8'h43, 4'hA, 16'h0000, word_adr(9), '0);
        req(0, 3'b011, 6'd63, 8'h44, 4'hB, 16'h0000, word_adr(40), '0);
        req(1, 3'b010, 6'd5, 8'h51, 4'hC, 16'hF0F0, word_adr(30), rnd128());
        req(0, 3'b000, 6'd0, 8'h52, 4'hD, 16'h0000, word_adr(30), '0);
        req(0, 3'b000, 6'd0, 8'h53, 4'hE, 16'h0000, word_adr(31), '0);

        for (int i = 0; i < 300; i++) begin
            a_r = ($urandom % 10 == 0) ? (32'h1000_0000 | ($urandom & 32'h0003FFF0))
                                       : (BASE | ($urandom & 32'h0003FFF0));
            req($urandom % 5 < 2, cti_tab[$urandom % 8],
                ($urandom % 4 == 0) ? 6'($urandom % 64) : 6'($urandom % 8),
                8'($urandom), 4'($urandom), 16'($urandom), a_r, rnd128());
            repeat ($urandom % 3) @(posedge clk_i);
            #1;
        end

        req(0, 3'b010, 6'd7, 8'h61, 4'h1, 16'h0000, word_adr(20), '0);
        @(posedge clk_i); #3;
        cs_i = 1; cyc_i = 1; stb_i = 1;
        rst_i = 0;
        exp_q.delete();
        #1;
        check("arst_ack", ack_o, 0);
        check("arst_err", err_o, 0);
        check("arst_next", next_o, 0);
        check("arst_dat", dat_o, 0);
        check("arst_side", (|tid_o) | (|cid_o) | (|adr_o), 0);
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1;
        cs_i = 0; cyc_i = 0; stb_i = 0;
        repeat (4) @(posedge clk_i);
        #1;
        busy_until = 0;
        req(0, 3'b010, 6'd7, 8'h71, 4'h2, 16'h0000, word_adr(20), '0);
        req(0, 3'b000, 6'd0, 8'h72, 4'h3, 16'h0000, word_adr(16), '0);

        for (int t = 0; t < 100 && exp_q.size() > 0; t++) @(posedge clk_i);
        repeat (2) @(posedge clk_i);
        check("drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
